// File: rtl/wir_ctrl_p.sv
// IEEE 1500 wrapper instruction register controller: WIR shift/update, decode, WBY bypass, WSO steering.
// Decode outputs change on the UpdateWR edge itself; WSO and the WBR strobes are combinational.
module wir_ctrl_p #(
  parameter int          WIR_W      = 3,
  parameter int unsigned OP_BYPASS  = 0,
  parameter int unsigned OP_EXTEST  = 1,
  parameter int unsigned OP_INTEST  = 2,
  parameter int unsigned OP_PRELOAD = 3
) (
  input  logic             WRCK,
  input  logic             WRST,
  input  logic             WSI,
  input  logic             SelectWIR,
  input  logic             CaptureWR,
  input  logic             ShiftWR,
  input  logic             UpdateWR,
  input  logic             wbr_so,
  output logic             WSO,
  output logic [WIR_W-1:0] instr,
  output logic             ws_bypass,
  output logic             ws_extest,
  output logic             ws_intest,
  output logic             ws_preload,
  output logic             illegal_op,
  output logic             wbr_capture,
  output logic             wbr_shift,
  output logic             wbr_update,
  output logic             wbr_mode
);

  localparam logic [WIR_W-1:0] OPC_BYP = WIR_W'(OP_BYPASS);
  localparam logic [WIR_W-1:0] OPC_EXT = WIR_W'(OP_EXTEST);
  localparam logic [WIR_W-1:0] OPC_INT = WIR_W'(OP_INTEST);
  localparam logic [WIR_W-1:0] OPC_PRE = WIR_W'(OP_PRELOAD);

  logic [WIR_W-1:0] wir_sr_q, wir_sr_d;
  logic [WIR_W-1:0] instr_q, instr_d;
  logic             byp_q, byp_d;
  logic             ext_q, ext_d;
  logic             int_q, int_d;
  logic             pre_q, pre_d;
  logic             ill_q, ill_d;
  logic             wby_q, wby_d;

  logic hit_byp, hit_ext, hit_int, hit_pre, legal;

  // Decode looks at the pre-edge shift register so Update can share an edge with Capture/Shift.
  assign hit_byp = (wir_sr_q == OPC_BYP);
  assign hit_ext = (wir_sr_q == OPC_EXT);
  assign hit_int = (wir_sr_q == OPC_INT);
  assign hit_pre = (wir_sr_q == OPC_PRE);
  assign legal   = hit_byp | hit_ext | hit_int | hit_pre;

  always_comb begin
    wir_sr_d = wir_sr_q;
    instr_d  = instr_q;
    byp_d    = byp_q;
    ext_d    = ext_q;
    int_d    = int_q;
    pre_d    = pre_q;
    ill_d    = ill_q;
    wby_d    = wby_q;
    if (SelectWIR) begin
      if (CaptureWR) begin
        wir_sr_d = instr_q;
      end else if (ShiftWR) begin
        wir_sr_d = {WSI, wir_sr_q[WIR_W-1:1]};
      end
      if (UpdateWR) begin
        instr_d = legal ? wir_sr_q : OPC_BYP;
        byp_d   = hit_byp | ~legal;
        ext_d   = hit_ext;
        int_d   = hit_int;
        pre_d   = hit_pre;
        ill_d   = ~legal;
      end
    end else if (byp_q) begin
      if (CaptureWR) begin
        wby_d = 1'b0;
      end else if (ShiftWR) begin
        wby_d = WSI;
      end
    end
  end

  always_ff @(posedge WRCK or posedge WRST) begin
    if (WRST) begin
      wir_sr_q <= '0;
      instr_q  <= OPC_BYP;
      byp_q    <= 1'b1;
      ext_q    <= 1'b0;
      int_q    <= 1'b0;
      pre_q    <= 1'b0;
      ill_q    <= 1'b0;
      wby_q    <= 1'b0;
    end else begin
      wir_sr_q <= wir_sr_d;
      instr_q  <= instr_d;
      byp_q    <= byp_d;
      ext_q    <= ext_d;
      int_q    <= int_d;
      pre_q    <= pre_d;
      ill_q    <= ill_d;
      wby_q    <= wby_d;
    end
  end

  assign instr       = instr_q;
  assign ws_bypass   = byp_q;
  assign ws_extest   = ext_q;
  assign ws_intest   = int_q;
  assign ws_preload  = pre_q;
  assign illegal_op  = ill_q;
  assign wbr_mode    = ext_q | int_q;

  // The WBR only sees strobes when it, not WBY, owns the data-register path.
  assign wbr_capture = ~SelectWIR & ~byp_q & CaptureWR;
  assign wbr_shift   = ~SelectWIR & ~byp_q & ShiftWR;
  assign wbr_update  = ~SelectWIR & ~byp_q & UpdateWR;

  assign WSO = SelectWIR ? wir_sr_q[0] : (byp_q ? wby_q : wbr_so);

endmodule

// File: tb/tb_wir_ctrl_p.sv
// Directed bench for wir_ctrl_p (WIR_W=3, opcodes 0..3): expectations queued by stimulus, checked by a monitor.
module tb_wir_ctrl_p;

  logic       WRCK = 1'b0;
  logic       WRST = 1'b0;
  logic       WSI = 1'b0, SelectWIR = 1'b0, CaptureWR = 1'b0, ShiftWR = 1'b0, UpdateWR = 1'b0;
  logic       wbr_so = 1'b0;
  logic       WSO;
  logic [2:0] instr;
  logic       ws_bypass, ws_extest, ws_intest, ws_preload, illegal_op;
  logic       wbr_capture, wbr_shift, wbr_update, wbr_mode;

  wir_ctrl_p dut (
    .WRCK(WRCK), .WRST(WRST), .WSI(WSI), .SelectWIR(SelectWIR),
    .CaptureWR(CaptureWR), .ShiftWR(ShiftWR), .UpdateWR(UpdateWR), .wbr_so(wbr_so),
    .WSO(WSO), .instr(instr), .ws_bypass(ws_bypass), .ws_extest(ws_extest),
    .ws_intest(ws_intest), .ws_preload(ws_preload), .illegal_op(illegal_op),
    .wbr_capture(wbr_capture), .wbr_shift(wbr_shift), .wbr_update(wbr_update),
    .wbr_mode(wbr_mode)
  );

  always #10 WRCK = ~WRCK;

  // obs layout: [12]WSO [11:9]instr [8]byp [7]ext [6]int [5]pre [4]ill [3]cap [2]sh [1]upd [0]mode
  typedef struct {
    string      name;
    logic [12:0] exp;
    logic [12:0] mask;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [12:0] obs;
  assign obs = {WSO, instr, ws_bypass, ws_extest, ws_intest, ws_preload, illegal_op,
                wbr_capture, wbr_shift, wbr_update, wbr_mode};

  initial begin
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_vec++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          n_miss++;
          $display("FAIL %s: got %b want %b (mask %b)", e.name, obs & e.mask, e.exp & e.mask, e.mask);
        end
      end
    end
  end

  task automatic push(input string name, input logic [12:0] exp, input logic [12:0] mask);
    exp_t e;
    #1;
    e.name = name;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // dec = {bypass, extest, intest, preload}
  task automatic check_state(input string name, input logic [2:0] ins, input logic [3:0] dec,
                             input logic ill, input logic mode);
    push(name, {1'b0, ins, dec, ill, 3'b000, mode}, 13'b0_111_1111_1_000_1);
  endtask

  // stb = {wbr_capture, wbr_shift, wbr_update}
  task automatic check_out(input string name, input logic wso, input logic [2:0] stb);
    push(name, {wso, 3'b000, 4'b0000, 1'b0, stb, 1'b0}, 13'b1_000_0000_0_111_0);
  endtask

  task automatic tick();
    @(posedge WRCK);
    #1;
  endtask

  task automatic idle();
    CaptureWR = 1'b0;
    ShiftWR   = 1'b0;
    UpdateWR  = 1'b0;
  endtask

  // Loads an opcode LSB first over three shift edges.
  task automatic shift_bits(input logic [2:0] b);
    SelectWIR = 1'b1;
    idle();
    ShiftWR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      WSI = b[i];
      tick();
    end
    ShiftWR = 1'b0;
  endtask

  task automatic do_update();
    SelectWIR = 1'b1;
    idle();
    UpdateWR = 1'b1;
    tick();
    UpdateWR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, well before the first rising edge at t=10.
    #3;
    WRST = 1'b1;
    check_state("rst_state", 3'd0, 4'b1000, 1'b0, 1'b0);
    SelectWIR = 1'b1;
    check_out("rst_wso_wir", 1'b0, 3'b000);
    SelectWIR = 1'b0;
    wbr_so = 1'b1;
    check_out("rst_wso_wby", 1'b0, 3'b000);
    WRST = 1'b0;
    wbr_so = 1'b0;

    // Load EXTEST.
    shift_bits(3'b001);
    check_out("ext_sr_wso", 1'b1, 3'b000);
    do_update();
    check_state("ext_load", 3'd1, 4'b0100, 1'b0, 1'b1);

    // Readback: capture then shift ones in; WSO shows 1,0,0.
    CaptureWR = 1'b1;
    tick();
    CaptureWR = 1'b0;
    check_out("rb_0", 1'b1, 3'b000);
    ShiftWR = 1'b1;
    WSI = 1'b1;
    tick();
    check_out("rb_1", 1'b0, 3'b000);
    tick();
    check_out("rb_2", 1'b0, 3'b000);
    idle();

    // Illegal opcode 6, then INTEST clears the flag.
    shift_bits(3'b110);
    do_update();
    check_state("illegal", 3'd0, 4'b1000, 1'b1, 1'b0);
    shift_bits(3'b010);
    check_state("ill_hold", 3'd0, 4'b1000, 1'b1, 1'b0);
    do_update();
    check_state("intest", 3'd2, 4'b0010, 1'b0, 1'b1);

    // WBR path with INTEST active.
    SelectWIR = 1'b0;
    wbr_so = 1'b1;
    check_out("wbr_so1", 1'b1, 3'b000);
    wbr_so = 1'b0;
    check_out("wbr_so0", 1'b0, 3'b000);
    wbr_so = 1'b1;
    ShiftWR = 1'b1;
    check_out("wbr_shift", 1'b1, 3'b010);
    tick();
    ShiftWR = 1'b0;
    CaptureWR = 1'b1;
    check_out("wbr_cap", 1'b1, 3'b100);
    tick();
    CaptureWR = 1'b0;
    UpdateWR = 1'b1;
    check_out("wbr_upd", 1'b1, 3'b001);
    tick();
    idle();
    check_state("wbr_hold", 3'd2, 4'b0010, 1'b0, 1'b1);
    SelectWIR = 1'b1;
    check_out("wir_sel", 1'b0, 3'b000);

    // Bypass path: capture+shift (capture wins), then WSI 1,1,0,1.
    shift_bits(3'b000);
    do_update();
    check_state("byp_load", 3'd0, 4'b1000, 1'b0, 1'b0);
    SelectWIR = 1'b0;
    wbr_so = 1'b1;
    CaptureWR = 1'b1;
    ShiftWR = 1'b1;
    WSI = 1'b1;
    check_out("byp_nostb", 1'b0, 3'b000);
    tick();
    CaptureWR = 1'b0;
    check_out("byp_cap", 1'b0, 3'b000);
    WSI = 1'b1; tick(); check_out("byp_s1", 1'b1, 3'b000);
    WSI = 1'b1; tick(); check_out("byp_s2", 1'b1, 3'b000);
    WSI = 1'b0; tick(); check_out("byp_s3", 1'b0, 3'b000);
    WSI = 1'b1; tick(); check_out("byp_s4", 1'b1, 3'b000);
    idle();

    // Shift+Update on one edge: instr takes pre-edge 011, sr becomes 101.
    shift_bits(3'b011);
    ShiftWR = 1'b1;
    UpdateWR = 1'b1;
    WSI = 1'b1;
    tick();
    idle();
    check_state("su_instr", 3'd3, 4'b0001, 1'b0, 1'b0);
    check_out("su_sr", 1'b1, 3'b000);
    // Capture+Shift: capture reloads 011 (WSO 1); a shift would give 010.
    CaptureWR = 1'b1;
    ShiftWR = 1'b1;
    WSI = 1'b0;
    tick();
    idle();
    check_out("cs_cap", 1'b1, 3'b000);

    // Reset after two of three shift edges.
    ShiftWR = 1'b1;
    WSI = 1'b1; tick();
    WSI = 1'b0; tick();
    idle();
    WRST = 1'b1;
    check_state("mid_rst", 3'd0, 4'b1000, 1'b0, 1'b0);
    check_out("mid_rst_wso", 1'b0, 3'b000);
    WRST = 1'b0;
    ShiftWR = 1'b1;
    WSI = 1'b1;
    tick();
    check_out("post_rst_1", 1'b0, 3'b000);
    tick();
    tick();
    idle();
    check_out("post_rst_3", 1'b1, 3'b000);
    do_update();
    check_state("post_rst_upd", 3'd0, 4'b1000, 1'b1, 1'b0);

    #5;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked entries want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
